// File: rtl/demux14_stream.sv
// 1-to-4 stream demultiplexer: each input word is queued in the FIFO of the
// channel named by in_sel and drained independently on that channel's valid/ready port.
module demux14_stream #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data0,
    output logic [DW-1:0] out_data1,
    output logic [DW-1:0] out_data2,
    output logic [DW-1:0] out_data3,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [3:0]    full,
    output logic          err_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    push;
    logic [3:0]    pop;
    logic [DW-1:0] head [4];
    logic          err_drop_q;
    logic          err_drop_d;

    // Ready depends only on stored occupancy, so a full channel never passes a word through.
    assign in_ready = !full[in_sel];

    always_comb begin
        push         = '0;
        push[in_sel] = in_valid && in_ready;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic [DW-1:0] mem_q [DEPTH];
            logic [AW-1:0] wr_ptr_q, wr_ptr_d;
            logic [AW-1:0] rd_ptr_q, rd_ptr_d;
            logic [CW-1:0] count_q, count_d;

            assign out_valid[gi] = (count_q != '0);
            assign full[gi]      = (count_q == CW'(DEPTH));
            assign pop[gi]       = out_valid[gi] && out_ready[gi];
            assign head[gi]      = out_valid[gi] ? mem_q[rd_ptr_q] : '0;

            always_comb begin
                wr_ptr_d = push[gi] ? wr_ptr_q + AW'(1) : wr_ptr_q;
                rd_ptr_d = pop[gi]  ? rd_ptr_q + AW'(1) : rd_ptr_q;
                count_d  = count_q;
                case ({push[gi], pop[gi]})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (push[gi]) begin
                    mem_q[wr_ptr_q] <= in_data;
                end
            end
        end
    endgenerate

    // Offering to a full channel is flagged even though the producer keeps the word.
    always_comb begin
        err_drop_d = err_drop_q | (in_valid && full[in_sel]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_drop_q <= 1'b0;
        end else begin
            err_drop_q <= err_drop_d;
        end
    end

    assign err_drop  = err_drop_q;
    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule

// File: tb/tb_demux14_stream.sv
// Self-checking bench for demux14_stream: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_demux14_stream;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [3:0]    full;
    logic          err_drop;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q [4][$];
    logic          m_err;

    demux14_stream #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dut_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic check_outputs(input string ph);
        logic [3:0] ev;
        logic [3:0] ef;
        for (int k = 0; k < 4; k++) begin
            ev[k] = (q[k].size() != 0);
            ef[k] = (q[k].size() == DEPTH);
            check($sformatf("%s data%0d", ph, k), 32'(dut_data(k)),
                  ev[k] ? 32'(q[k][0]) : 32'h0);
        end
        check({ph, " out_valid"}, 32'(out_valid), 32'(ev));
        check({ph, " full"}, 32'(full), 32'(ef));
        check({ph, " err_drop"}, 32'(err_drop), 32'(m_err));
    endtask

    // One clock: drive, check at negedge, then advance the model on the posedge.
    task automatic step(input logic [DW-1:0] d, input logic [1:0] s, input logic v,
                        input logic [3:0] ordy);
        logic       exp_rdy;
        logic       do_push;
        logic [3:0] do_pop;
        in_data   = d;
        in_sel    = s;
        in_valid  = v;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (q[s].size() < DEPTH);
        check_outputs("cyc");
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        do_push = v && exp_rdy;
        for (int k = 0; k < 4; k++) do_pop[k] = (q[k].size() != 0) && ordy[k];
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (do_pop[k]) begin
                $display("pop  ch=%0d data=%h", k, q[k][0]);
                void'(q[k].pop_front());
            end
        end
        if (do_push) begin
            q[s].push_back(d);
            $display("push ch=%0d data=%h", s, d);
        end
        if (v && !exp_rdy) m_err = 1'b1;
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) q[k].delete();
        m_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
        model_reset();
        #12;
        check_outputs("reset");
        check("reset in_ready", 32'(in_ready), 32'h1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single push to channel 2, visible right after the edge.
        step(16'hA5A5, 2'd2, 1'b1, 4'b0000);
        step(16'h0000, 2'd0, 1'b0, 4'b0000);
        check("ch2 valid", 32'(out_valid), 32'h4);
        check("ch2 data", 32'(out_data2), 32'hA5A5);
        step(16'h0000, 2'd0, 1'b0, 4'b0100);

        // Fill channel 0, offer a 5th word while full, then drain in order.
        for (int i = 1; i <= 4; i++) step(16'(i), 2'd0, 1'b1, 4'b0000);
        step(16'h0005, 2'd0, 1'b1, 4'b0000);
        check("ch0 full", 32'(full), 32'h1);
        check("ch0 err", 32'(err_drop), 32'h1);
        step(16'h0005, 2'd0, 1'b1, 4'b0001);
        step(16'h0005, 2'd0, 1'b1, 4'b0001);
        for (int i = 0; i < 5; i++) step(16'h0000, 2'd0, 1'b0, 4'b0001);
        check("ch0 empty", 32'(out_valid), 32'h0);

        // Continuous streaming through channel 1 across several pointer wraps.
        for (int i = 1; i <= 12; i++) step(16'(i), 2'd1, 1'b1, 4'b0010);
        step(16'h0000, 2'd0, 1'b0, 4'b0010);

        // Round-robin with random consumers.
        for (int i = 0; i < 4; i++) step(16'h1000 + 16'(i), 2'(i), 1'b1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 6; i++) step(16'h0000, 2'd0, 1'b0, 4'b1111);

        // Mid-cycle asynchronous reset with channel 3 partly filled.
        step(16'hBEEF, 2'd3, 1'b1, 4'b0000);
        step(16'hCAFE, 2'd3, 1'b1, 4'b0000);
        step(16'h0000, 2'd0, 1'b1, 4'b0000);
        step(16'h0000, 2'd0, 1'b0, 4'b0000);
        m_err = 1'b1;
        step(16'h0001, 2'd0, 1'b1, 4'b0000);
        check("pre-rst err", 32'(err_drop), 32'h1);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async out_valid", 32'(out_valid), 32'h0);
        check("async full", 32'(full), 32'h0);
        check("async err", 32'(err_drop), 32'h0);
        check("async data3", 32'(out_data3), 32'h0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        step(16'h7777, 2'd3, 1'b1, 4'b0000);
        step(16'h0000, 2'd0, 1'b0, 4'b1000);

        // Full channel 2: pop and refused push on the same edge, push next cycle.
        for (int i = 0; i < 4; i++) step(16'h2200 + 16'(i), 2'd2, 1'b1, 4'b0000);
        step(16'h22FF, 2'd2, 1'b1, 4'b0100);
        check("ch2 not full", 32'(full), 32'h0);
        step(16'h22FF, 2'd2, 1'b1, 4'b0000);
        check("ch2 refilled", 32'(full), 32'h4);
        for (int i = 0; i < 5; i++) step(16'h0000, 2'd0, 1'b0, 4'b0100);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        for (int i = 0; i < 6; i++) step(16'h0000, 2'd0, 1'b0, 4'b1111);
        check_outputs("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux14_stream.md
Name: demux14_stream

Overview:
- 1-to-4 demultiplexing stream router on the 16-bit datapath; the inverse of the existing 4:1 select mux.
- Accepts one 16-bit word per cycle with a 2-bit destination select and a valid/ready handshake.
- Queues each word in a per-destination FIFO and presents it on one of four valid/ready output channels.
- Sits between a single producer and up to four consumers that drain independently.

Parameters:
- DEPTH, 4, entries per output FIFO; power of two, minimum 2.
- DW, 16, data width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DW  input word.
- in_sel  input  2  destination channel, 0..3.
- in_valid  input  1  producer has a word.
- in_ready  output  1  router can accept to channel in_sel.
- out_data0..out_data3  output  DW each  head word of channel k.
- out_valid  output  4  bit k set: channel k head word valid.
- out_ready  input  4  bit k set: consumer k accepts its head word.
- full  output  4  bit k set: channel k FIFO holds DEPTH entries.
- err_drop  output  1  sticky; set when a word is offered to a full channel.

Behaviour:
- Reset (async assert, sync release):
  - All FIFO pointers and counts go to 0.
  - out_valid = 4'b0000, full = 4'b0000, err_drop = 0, all out_dataK = 0.
  - in_ready = 1, since every channel is empty.
  - Words held before a mid-stream reset are discarded; no partial transfer survives.
- Input handshake:
  - in_ready = !full[in_sel]. This is combinational from in_sel and registered counts only, never from out_ready.
  - A push to channel in_sel happens on a rising edge where in_valid && in_ready.
  - No other channel is affected by the push.
- Output handshake:
  - Channel k pops on a rising edge where out_valid[k] && out_ready[k].
  - out_valid[k] = (count_k != 0). out_dataK = head entry of FIFO k, or 0 when the FIFO is empty.
  - out_dataK and out_valid[k] are stable while out_valid[k]=1 and out_ready[k]=0.
- Latency:
  - A word accepted at edge N is visible at channel k right after edge N.
  - The earliest pop is edge N+1; there is no same-cycle fall-through.
- Ordering:
  - Strict FIFO order within each channel.
  - No ordering is guaranteed between channels.
- Per-channel counter, count_k, width clog2(DEPTH)+1:
  - push only: +1.
  - pop only: -1.
  - push and pop on the same edge: unchanged. Write pointer and read pointer both advance and the data stays correct.
- Pointers:
  - log2(DEPTH) bits, wrapping modulo DEPTH.
  - full[k] = (count_k == DEPTH).
- Full channel:
  - in_ready is 0 even if out_ready[k]=1 on the same cycle; there is no pass-through when full.
  - The word is not written, and the producer must hold it.
  - If in_valid=1 while full[in_sel]=1, err_drop sets on that edge and stays set until rst.
  - A held word is not lost, but the flag marks the backpressure event.
- in_sel changes while in_valid=1 and in_ready=0 are legal. in_ready re-evaluates against the new channel.
- out_ready bits for empty channels are ignored.
- All four channels may pop on the same edge as a push.

Test Plan:
- Reset, then in_sel=2, in_data=16'hA5A5, one-cycle push with out_ready=0 -> at the next edge out_valid=4'b0100, out_data2=16'hA5A5, count_2=1. Other channels stay at 0.
- Push 16'h0001..16'h0004 to channel 0 with out_ready=0 -> full=4'b0001 after the 4th edge. A 5th word 16'h0005 sees in_ready=0 and err_drop=1. Raising out_ready[0] drains 1,2,3,4 in order; 5 is then accepted and drains last.
- Push to channel 1 continuously with out_ready[1]=1 every cycle -> count_1 stays at 1 in steady state. Outputs 1,2,3,... appear one per cycle with 1-cycle latency and no bubbles. Pointers wrap past DEPTH cleanly over 10 or more words.
- Round-robin in_sel=0,1,2,3 with words 16'h1000..16'h1003 and random out_ready -> each channel receives exactly its word. No cross-channel leakage.
- Fill channel 3 to 2 entries, assert rst mid-cycle for less than one clock period -> out_valid=0, full=0, err_drop=0 immediately (async). After release, pushes work from empty.
- Channel 2 full, out_ready[2]=1 and in_valid=1 to channel 2 on the same cycle -> pop occurs, push refused (in_ready=0), count_2=DEPTH-1. The push succeeds on the next cycle.
